// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR tap table, successor function, lock states and lockup word
package lfsr_pkg;

    localparam int MAX_BITS = 12;
    localparam logic [MAX_BITS-1:0] LOCKUP = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } lfsr_state_t;

    // Bit n-1 of the mask is set for tap n (taps are numbered from 1).
    function automatic logic [MAX_BITS-1:0] taps(input int n);
        case (n)
            3:       taps = 12'h006;
            4:       taps = 12'h00C;
            5:       taps = 12'h014;
            6:       taps = 12'h030;
            7:       taps = 12'h060;
            8:       taps = 12'h0B8;
            9:       taps = 12'h110;
            10:      taps = 12'h240;
            11:      taps = 12'h500;
            12:      taps = 12'h829;
            default: taps = 12'h000;
        endcase
    endfunction

    function automatic logic [MAX_BITS-1:0] lfsr_next(input logic [MAX_BITS-1:0] w, input int n);
        logic [MAX_BITS-1:0] width_mask;
        width_mask = MAX_BITS'((1 << n) - 1);
        lfsr_next  = ((w << 1) | MAX_BITS'(~^(w & taps(n)))) & width_mask;
    endfunction

endpackage

// File: rtl/lfsr_next_comb.sv
// rtl/lfsr_next_comb.sv - combinational XNOR-feedback LFSR successor of one state word
module lfsr_next_comb
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] w,
    output logic [NUM_BITS-1:0] next_w
);

    localparam logic [NUM_BITS-1:0] TAP_MASK = NUM_BITS'(taps(NUM_BITS));

    assign next_w = {w[NUM_BITS-2:0], ~^(w & TAP_MASK)};

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising LFSR word-stream checker with error count and period measurement
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int NUM_BITS   = 4,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Data_DV,
    input  logic [NUM_BITS-1:0] i_Data,
    input  logic                i_Clear,
    output logic                o_Locked,
    output logic                o_Error,
    output logic [ERR_W-1:0]    o_Err_Count,
    output logic                o_Period_Done,
    output logic [NUM_BITS-1:0] o_Period_Len
);

    localparam int MW = $clog2(LOCK_COUNT + 2);
    localparam int LW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
    localparam logic [NUM_BITS-1:0] ALL_ONES = NUM_BITS'(LOCKUP);

    lfsr_state_t         state;
    logic [NUM_BITS-1:0] expect_w;
    logic [NUM_BITS-1:0] ref_w;
    logic [NUM_BITS-1:0] period_cnt;
    logic [MW-1:0]       match_cnt;
    logic [LW-1:0]       miss_cnt;
    logic [NUM_BITS-1:0] data_next;
    logic [NUM_BITS-1:0] exp_next;

    lfsr_next_comb #(.NUM_BITS(NUM_BITS)) u_next_data (
        .w      (i_Data),
        .next_w (data_next)
    );

    lfsr_next_comb #(.NUM_BITS(NUM_BITS)) u_next_exp (
        .w      (expect_w),
        .next_w (exp_next)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= SEARCH;
            expect_w      <= '0;
            ref_w         <= '0;
            period_cnt    <= '0;
            match_cnt     <= '0;
            miss_cnt      <= '0;
            o_Locked      <= 1'b0;
            o_Error       <= 1'b0;
            o_Err_Count   <= '0;
            o_Period_Done <= 1'b0;
            o_Period_Len  <= '0;
        end else begin
            o_Error       <= 1'b0;
            o_Period_Done <= 1'b0;
            if (i_Clear) begin
                o_Err_Count  <= '0;
                o_Period_Len <= '0;
            end
            if (i_Data_DV) begin
                case (state)
                    SEARCH: begin
                        if (i_Data != ALL_ONES) begin
                            expect_w  <= data_next;
                            match_cnt <= MW'(1);
                            state     <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        if (i_Data == expect_w) begin
                            expect_w  <= data_next;
                            match_cnt <= match_cnt + MW'(1);
                            if (int'(match_cnt) + 1 > LOCK_COUNT) begin
                                state      <= LOCKED;
                                o_Locked   <= 1'b1;
                                ref_w      <= i_Data;
                                period_cnt <= '0;
                                miss_cnt   <= '0;
                            end
                        end else if (i_Data != ALL_ONES) begin
                            expect_w  <= data_next;
                            match_cnt <= MW'(1);
                        end else begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Advance from the expected word so one corrupted word costs one error.
                        expect_w <= exp_next;
                        if (i_Data == expect_w) begin
                            miss_cnt <= '0;
                            if (i_Data == ref_w) begin
                                o_Period_Done <= 1'b1;
                                o_Period_Len  <= period_cnt + NUM_BITS'(1);
                                period_cnt    <= '0;
                            end else begin
                                period_cnt <= period_cnt + NUM_BITS'(1);
                            end
                        end else begin
                            period_cnt <= period_cnt + NUM_BITS'(1);
                            o_Error    <= 1'b1;
                            if (i_Clear) begin
                                o_Err_Count <= ERR_W'(1);
                            end else if (o_Err_Count != '1) begin
                                o_Err_Count <= o_Err_Count + ERR_W'(1);
                            end
                            if (int'(miss_cnt) + 1 >= LOSS_COUNT) begin
                                state     <= SEARCH;
                                o_Locked  <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + LW'(1);
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule
